oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/gb_pkg.sv | 17 +
 rtl/oam_dma.sv | 127 ++++++++++++
 tb/tb_oam_dma.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// Shared types and constants for the Game Boy style OAM DMA block.
package gb_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE     = 2'd0,
    DMA_STARTING = 2'd1,
    DMA_ACTIVE   = 2'd2
  } dma_state_e;

  localparam int          OAM_LEN_DEFAULT = 160;
  localparam logic [15:0] DMA_REG_ADDR    = 16'hFF46;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= 16'hFF80) && (addr <= 16'hFFFE);
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies OAM_LEN bytes from {src,00} into OAM, one byte per
// M-cycle, while arbitrating the CPU against the shared bus and HRAM port.
module oam_dma
  import gb_pkg::*;
#(
  parameter int          OAM_LEN = OAM_LEN_DEFAULT,
  parameter logic [15:0] DMA_REG = DMA_REG_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_cycle,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_read_enable,
  input  logic        cpu_write_enable,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  output logic [15:0] bus_addr,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic [6:0]  hi_addr,
  output logic        hi_read_enable,
  output logic        hi_write_enable,
  output logic [7:0]  hi_data_out,
  input  logic [7:0]  hi_data_in,
  output logic [7:0]  oam_addr,
  output logic        oam_write_enable,
  output logic [7:0]  oam_data,
  output logic        dma_active,
  output dma_state_e  dbg_state
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;

  logic dma_reg_write;
  logic active;

  assign dma_reg_write = m_cycle && cpu_write_enable && (cpu_addr == DMA_REG);
  assign active        = (state_q == DMA_ACTIVE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DMA_IDLE;
      src_q   <= 8'h00;
      idx_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
    end
  end

  // A DMA_REG write wins over every other transition, including the final
  // Active M-cycle, so back-to-back and mid-transfer restarts need no gap.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    if (dma_reg_write) begin
      state_d = DMA_STARTING;
      src_d   = cpu_data_out;
      idx_d   = 8'h00;
    end else if (m_cycle) begin
      unique case (state_q)
        DMA_STARTING: state_d = DMA_ACTIVE;
        DMA_ACTIVE: begin
          if (idx_q == LAST_IDX) begin
            state_d = DMA_IDLE;
            idx_d   = 8'h00;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        default: state_d = DMA_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_data_in      = bus_data_in;
    bus_addr         = cpu_addr;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    bus_data_out     = cpu_data_out;
    hi_addr          = 7'h00;
    hi_read_enable   = 1'b0;
    hi_write_enable  = 1'b0;
    hi_data_out      = 8'h00;

    if (is_hram(cpu_addr)) begin
      hi_addr         = cpu_addr[6:0];
      hi_read_enable  = cpu_read_enable;
      hi_write_enable = cpu_write_enable;
      hi_data_out     = cpu_data_out;
      cpu_data_in     = hi_data_in;
    end else if (cpu_addr == DMA_REG) begin
      cpu_data_in      = src_q;
      bus_read_enable  = cpu_read_enable;
      bus_write_enable = cpu_write_enable;
    end else if (active) begin
      cpu_data_in = 8'hFF;
    end else begin
      bus_read_enable  = cpu_read_enable;
      bus_write_enable = cpu_write_enable;
    end

    // During Active the DMA owns the bus regardless of the CPU request.
    if (active) begin
      bus_addr         = {src_q, idx_q};
      bus_read_enable  = 1'b1;
      bus_write_enable = 1'b0;
      bus_data_out     = 8'h00;
    end

    oam_write_enable = active && m_cycle;
    oam_addr         = idx_q;
    oam_data         = bus_data_in;
    dma_active       = (state_q != DMA_IDLE);
    dbg_state        = state_q;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: expected OAM writes are queued as transfers are
// started and a negedge monitor pops and compares each observed write.
module tb_oam_dma;
  import gb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  tcnt = 2'd0;
  logic        m_cycle;
  logic [15:0] cpu_addr;
  logic        cpu_read_enable;
  logic        cpu_write_enable;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic [15:0] bus_addr;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic [6:0]  hi_addr;
  logic        hi_read_enable;
  logic        hi_write_enable;
  logic [7:0]  hi_data_out;
  logic [7:0]  hi_data_in;
  logic [7:0]  oam_addr;
  logic        oam_write_enable;
  logic [7:0]  oam_data;
  logic        dma_active;
  dma_state_e  dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  // Clock / M-cycle strobe / memory models
  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign m_cycle     = (tcnt == 2'd3);
  assign bus_data_in = bus_addr[15:8] ^ bus_addr[7:0];
  assign hi_data_in  = 8'h5A;

  oam_dma dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m_cycle          (m_cycle),
    .cpu_addr         (cpu_addr),
    .cpu_read_enable  (cpu_read_enable),
    .cpu_write_enable (cpu_write_enable),
    .cpu_data_out     (cpu_data_out),
    .cpu_data_in      (cpu_data_in),
    .bus_addr         (bus_addr),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_data_out     (bus_data_out),
    .bus_data_in      (bus_data_in),
    .hi_addr          (hi_addr),
    .hi_read_enable   (hi_read_enable),
    .hi_write_enable  (hi_write_enable),
    .hi_data_out      (hi_data_out),
    .hi_data_in       (hi_data_in),
    .oam_addr         (oam_addr),
    .oam_write_enable (oam_write_enable),
    .oam_data         (oam_data),
    .dma_active       (dma_active),
    .dbg_state        (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each entry is {oam_addr, oam_data, bus_addr}
  always @(negedge clk) begin
    if (oam_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL oam_unexpected: got write addr %h data %h, expected none", oam_addr, oam_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("oam_write", {oam_addr, oam_data, bus_addr}, mon_exp);
      end
    end
  end

  // Driver tasks
  task automatic cpu_set(input logic [15:0] a, input logic re, input logic we, input logic [7:0] d);
    cpu_addr         = a;
    cpu_read_enable  = re;
    cpu_write_enable = we;
    cpu_data_out     = d;
  endtask

  task automatic cpu_idle();
    cpu_set(16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic next_mc();
    do @(negedge clk); while (m_cycle !== 1'b1);
  endtask

  task automatic wait_off();
    do @(negedge clk); while (m_cycle !== 1'b0);
  endtask

  task automatic run_to_idx(input int k);
    repeat (k + 2) next_mc();
  endtask

  task automatic push_xfer(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({8'(i), s ^ 8'(i), s, 8'(i)});
  endtask

  // Caller must be at an m_cycle negedge; the write lands on the next edge.
  task automatic start_dma(input logic [7:0] s, input int n);
    push_xfer(s, n);
    cpu_set(16'hFF46, 1'b0, 1'b1, s);
    @(posedge clk);
    #1 cpu_idle();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dma_active === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("dma_done", 32'(dma_active), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_oam_we", 32'(oam_write_enable), 32'd0);
    check("rst_bus_en", {30'd0, bus_read_enable, bus_write_enable}, 32'd0);
    check("rst_hi_en", {30'd0, hi_read_enable, hi_write_enable}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(DMA_IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    // Idle pass-through
    wait_off(); cpu_set(16'hC012, 1'b1, 1'b0, 8'h00); #1;
    check("idle_rd_addr", 32'(bus_addr), 32'hC012);
    check("idle_rd_en", {30'd0, bus_read_enable, bus_write_enable}, 32'h2);
    check("idle_rd_data", 32'(cpu_data_in), 32'hD2);
    wait_off(); cpu_set(16'h8000, 1'b0, 1'b1, 8'h3C); #1;
    check("idle_wr", {bus_addr, bus_data_out, 6'd0, bus_read_enable, bus_write_enable}, 32'h8000_3C01);
    wait_off(); cpu_set(16'hFF46, 1'b0, 1'b1, 8'h77); #1;
    check("idle_reg_wr_pass", {bus_addr, bus_data_out, 6'd0, bus_read_enable, bus_write_enable}, 32'hFF46_7701);
    wait_off(); cpu_set(16'hFF46, 1'b1, 1'b0, 8'h00); #1;
    check("reg_rd_after_rst", 32'(cpu_data_in), 32'h00);
    wait_off(); cpu_set(16'hFF90, 1'b1, 1'b0, 8'h00); #1;
    check("idle_hi_rd", {17'd0, hi_addr, 6'd0, hi_read_enable, bus_read_enable}, {17'd0, 7'h10, 8'h02});
    check("idle_hi_data", 32'(cpu_data_in), 32'h5A);
    cpu_idle();

    // Full transfer from C100 with CPU accesses during Active
    next_mc(); start_dma(8'hC1, 160);
    next_mc();
    check("start_state", {30'd0, dma_active, oam_write_enable}, 32'h2);
    check("start_dbg", 32'(dbg_state), 32'(DMA_STARTING));
    next_mc();
    check("first_bus_addr", {bus_addr, 8'd0, 6'd0, bus_read_enable, bus_write_enable}, 32'hC100_0002);
    repeat (10) next_mc();
    cpu_set(16'hC000, 1'b1, 1'b0, 8'h00); #1;
    check("act_rd_ff", 32'(cpu_data_in), 32'hFF);
    check("act_rd_bus", {bus_addr, 14'd0, bus_read_enable, bus_write_enable}, 32'hC10A_0002);
    cpu_set(16'hC000, 1'b0, 1'b1, 8'h55); #1;
    check("act_wr_drop", {bus_addr, 14'd0, bus_read_enable, bus_write_enable}, 32'hC10A_0002);
    @(posedge clk); #1 cpu_idle();
    next_mc();
    cpu_set(16'hFF90, 1'b1, 1'b0, 8'h00); #1;
    check("act_hi_rd", {9'd0, hi_addr, cpu_data_in, 6'd0, hi_read_enable, hi_write_enable}, {9'd0, 7'h10, 8'h5A, 8'h02});
    check("act_hi_rd_bus", {bus_addr, 14'd0, bus_read_enable, bus_write_enable}, 32'hC10B_0002);
    cpu_set(16'hFF90, 1'b0, 1'b1, 8'hA7); #1;
    check("act_hi_wr", {9'd0, hi_addr, hi_data_out, 6'd0, hi_read_enable, hi_write_enable}, {9'd0, 7'h10, 8'hA7, 8'h01});
    check("act_hi_wr_bus", {bus_addr, 14'd0, bus_read_enable, bus_write_enable}, 32'hC10B_0002);
    @(posedge clk); #1 cpu_idle();
    next_mc();
    cpu_set(16'hFF46, 1'b1, 1'b0, 8'h00); #1;
    check("act_reg_rd", 32'(cpu_data_in), 32'hC1);
    cpu_idle();
    wait_idle();
    check("done_state", 32'(dbg_state), 32'(DMA_IDLE));

    // Restart at idx 50 to D000
    next_mc(); start_dma(8'hC1, 51);
    run_to_idx(50);
    check("rs_pre_addr", 32'(bus_addr), 32'hC132);
    start_dma(8'hD0, 160);
    next_mc();
    check("rs_starting", {30'd0, dma_active, oam_write_enable}, 32'h2);
    next_mc();
    check("rs_first", {bus_addr, oam_addr, 7'd0, oam_write_enable}, 32'hD000_0001);
    wait_idle();

    // Back-to-back: restart on the final Active M-cycle
    next_mc(); start_dma(8'hC4, 160);
    run_to_idx(159);
    check("b2b_last_addr", 32'(bus_addr), 32'hC49F);
    start_dma(8'hC5, 160);
    check("b2b_no_gap", 32'(dma_active), 32'd1);
    next_mc();
    check("b2b_starting", 32'(dbg_state), 32'(DMA_STARTING));
    next_mc();
    check("b2b_first", 32'(bus_addr), 32'hC500);
    wait_idle();

    // Asynchronous reset at idx 80
    next_mc(); start_dma(8'hC3, 80);
    run_to_idx(79);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("ar_clear", {29'd0, dma_active, oam_write_enable, bus_read_enable}, 32'd0);
    check("ar_state", 32'(dbg_state), 32'(DMA_IDLE));
    check("ar_hi_en", {30'd0, hi_read_enable, hi_write_enable}, 32'd0);
    repeat (12) @(negedge clk);
    check("ar_queue", 32'(exp_q.size()), 32'd0);
    reset_n = 1'b1;
    repeat (8) next_mc();
    check("ar_idle_after", 32'(dma_active), 32'd0);
    wait_off(); cpu_set(16'hFF46, 1'b1, 1'b0, 8'h00); #1;
    check("ar_reg_rd", 32'(cpu_data_in), 32'h00);
    cpu_idle();

    repeat (4) @(negedge clk);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
